// File: rtl/latch_bank_arbiter.sv
// Round-robin arbiter sequencing two write ports onto one D-latch bank: setup, enable pulse, hold.
// Grant lands one edge after req; requesters hold req until done, and later requests wait in IDLE.
module latch_bank_arbiter #(
   parameter int WIDTH = 8,
   parameter int SETUP = 1,
   parameter int PULSE = 2,
   parameter int HOLD  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] wdata0,
   input  logic [WIDTH-1:0] wdata1,
   output logic [1:0]       gnt,
   output logic [1:0]       done,
   output logic             busy,
   output logic [WIDTH-1:0] D,
   output logic             C
);

   localparam int MAXC = (SETUP > PULSE) ? ((SETUP > HOLD) ? SETUP : HOLD)
                                         : ((PULSE > HOLD) ? PULSE : HOLD);
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_PULSE = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   logic [1:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic             r_ptr;
   logic [1:0]       r_gnt;
   logic [1:0]       r_done;
   logic             r_busy;
   logic [WIDTH-1:0] r_d;
   logic             r_c;
   logic             w_win;

   // r_ptr=1 favours requester 1 when both ask
   assign w_win = (req == 2'b10) || ((req == 2'b11) && r_ptr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ptr   <= 1'b0;
         r_gnt   <= 2'b00;
         r_done  <= 2'b00;
         r_busy  <= 1'b0;
         r_d     <= '0;
         r_c     <= 1'b0;
      end else begin
         r_done <= 2'b00;
         case (r_state)
            S_IDLE: begin
               if (req != 2'b00) begin
                  r_state <= S_SETUP;
                  r_cnt   <= CW'(SETUP - 1);
                  r_d     <= w_win ? wdata1 : wdata0;
                  r_gnt   <= w_win ? 2'b10 : 2'b01;
                  r_busy  <= 1'b1;
                  r_ptr   <= ~w_win;
               end
            end
            S_SETUP: begin
               if (r_cnt == '0) begin
                  r_state <= S_PULSE;
                  r_cnt   <= CW'(PULSE - 1);
                  r_c     <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_PULSE: begin
               if (r_cnt == '0) begin
                  r_state <= S_HOLD;
                  r_cnt   <= CW'(HOLD - 1);
                  r_c     <= 1'b0;
                  if (HOLD == 1) r_done <= r_gnt;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_HOLD: begin
               if (r_cnt == '0) begin
                  r_state <= S_IDLE;
                  r_gnt   <= 2'b00;
                  r_busy  <= 1'b0;
               end else begin
                  // done is registered, so raise it on entry to the final hold cycle
                  r_cnt <= r_cnt - CW'(1);
                  if (r_cnt == CW'(1)) r_done <= r_gnt;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign gnt  = r_gnt;
   assign done = r_done;
   assign busy = r_busy;
   assign D    = r_d;
   assign C    = r_c;

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Scoreboard bench for latch_bank_arbiter: directed writes push expected {winner, data}; a monitor checks on done.
module tb_latch_bank_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [1:0] req = 2'b00;
   logic [7:0] wdata0 = 8'h00;
   logic [7:0] wdata1 = 8'h00;
   logic [1:0] gnt;
   logic [1:0] done;
   logic       busy;
   logic [7:0] D;
   logic       C;

   latch_bank_arbiter #(.WIDTH(8), .SETUP(1), .PULSE(2), .HOLD(1)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .wdata0 (wdata0),
      .wdata1 (wdata1),
      .gnt    (gnt),
      .done   (done),
      .busy   (busy),
      .D      (D),
      .C      (C)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] who;
      logic [7:0] dat;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   total = 0;
   int   bad = 0;
   int   n_done = 0;
   int   cyc = 0;
   int   start = 0;
   int   c_cnt = 0;
   int   c_first = -1;
   int   saved;
   logic [1:0] prev_gnt = 2'b00;
   logic [1:0] prev_done = 2'b00;
   logic [7:0] prev_d = 8'h00;
   logic       prev_c = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor: invariants every cycle, scoreboard pop on each done pulse
   always @(negedge clk) begin
      check("gnt_onehot", {31'b0, $countones(gnt) <= 1}, 1);
      check("done_in_gnt", {30'b0, done & ~gnt}, 0);
      if (prev_done != 2'b00) begin
         check("idle_gnt", {30'b0, gnt}, 0);
         check("idle_busy", {31'b0, busy}, 0);
      end
      if (gnt != 2'b00 && prev_gnt != 2'b00) check("d_stable", {24'b0, D}, {24'b0, prev_d});
      if (C && !prev_c) check("c_rise_d", {24'b0, D}, {24'b0, prev_d});
      if (gnt != 2'b00 && prev_gnt == 2'b00) begin
         start   = cyc;
         c_cnt   = 0;
         c_first = -1;
         check("busy_on_gnt", {31'b0, busy}, 1);
      end
      if (C) begin
         c_cnt++;
         if (c_first < 0) c_first = cyc;
      end
      if (done != 2'b00) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got %b want none (t=%0t)", done, $time);
         end else begin
            e = q.pop_front();
            check("done_who", {30'b0, done}, {30'b0, e.who});
            check("done_data", {24'b0, D}, {24'b0, e.dat});
            check("latency", cyc - start, 3);
            check("c_width", c_cnt, 2);
            check("c_offset", c_first - start, 1);
         end
         n_done++;
      end
      prev_gnt  = gnt;
      prev_done = done;
      prev_d    = D;
      prev_c    = C;
   end

   task automatic wait_dones(input int n, input int budget, input string name);
      int target;
      int k;
      target = n_done + n;
      k = 0;
      while (n_done < target && k < budget) begin
         @(posedge clk);
         k++;
      end
      check(name, {31'b0, n_done >= target}, 1);
   endtask

   task automatic wait_c(input int budget, input string name);
      int k;
      k = 0;
      @(negedge clk);
      while (!C && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, {31'b0, C}, 1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_gnt"}, {30'b0, gnt}, 0);
      check({tag, "_done"}, {30'b0, done}, 0);
      check({tag, "_busy"}, {31'b0, busy}, 0);
      check({tag, "_d"}, {24'b0, D}, 0);
      check({tag, "_c"}, {31'b0, C}, 0);
   endtask

   initial begin
      #3 rst_n = 1'b0;
      #1 check_zero("reset");
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Contention straight after reset: 0 first, then 1
      @(posedge clk);
      #1 wdata0 = 8'h11; wdata1 = 8'h22; req = 2'b11;
      q.push_back(exp_t'{2'b01, 8'h11});
      q.push_back(exp_t'{2'b10, 8'h22});
      wait_dones(2, 30, "contention_wait");
      #1 req = 2'b00;

      // Fairness: both held for four transactions
      @(posedge clk);
      #1 wdata0 = 8'h33; wdata1 = 8'h44; req = 2'b11;
      q.push_back(exp_t'{2'b01, 8'h33});
      q.push_back(exp_t'{2'b10, 8'h44});
      q.push_back(exp_t'{2'b01, 8'h33});
      q.push_back(exp_t'{2'b10, 8'h44});
      wait_dones(4, 60, "fairness_wait");
      #1 req = 2'b00;

      // Requester 1 alone while pointer favours 0
      @(posedge clk);
      #1 wdata1 = 8'h55; req = 2'b10;
      q.push_back(exp_t'{2'b10, 8'h55});
      wait_dones(1, 20, "alone_wait");
      #1 req = 2'b00;

      // Single write, then D must hold in IDLE
      @(posedge clk);
      #1 wdata0 = 8'hA5; req = 2'b01;
      q.push_back(exp_t'{2'b01, 8'hA5});
      wait_dones(1, 20, "single_wait");
      #1 req = 2'b00;
      @(posedge clk);
      @(posedge clk);
      #1 check("d_hold_idle", {24'b0, D}, 32'hA5);
      check("busy_idle", {31'b0, busy}, 0);

      // wdata0 churns every cycle after grant
      @(posedge clk);
      #1 wdata0 = 8'h66; req = 2'b01;
      q.push_back(exp_t'{2'b01, 8'h66});
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               @(posedge clk);
               #2 wdata0 = wdata0 + 8'h01;
            end
         end
         begin
            wait_dones(1, 20, "stable_wait");
            #1 req = 2'b00;
         end
      join

      // req dropped during the enable pulse
      @(posedge clk);
      #1 wdata0 = 8'h77; req = 2'b01;
      q.push_back(exp_t'{2'b01, 8'h77});
      wait_c(20, "drop_c_wait");
      @(posedge clk);
      #1 req = 2'b00;
      wait_dones(1, 20, "drop_wait");

      // Asynchronous reset between edges mid-pulse
      @(posedge clk);
      #1 wdata0 = 8'h88; req = 2'b01;
      q.push_back(exp_t'{2'b01, 8'h88});
      wait_c(20, "rst_c_wait");
      #2 rst_n = 1'b0;
      req = 2'b00;
      void'(q.pop_back());
      saved = n_done;
      #1 check_zero("midrst");
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      check("no_done_after_rst", n_done, saved);
      wdata1 = 8'h99;
      req = 2'b10;
      q.push_back(exp_t'{2'b10, 8'h99});
      wait_dones(1, 20, "post_rst_wait");
      #1 req = 2'b00;

      repeat (4) @(posedge clk);
      #1 check("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
